common_prog_delay_line_w_valid: RTL and testbench
=================================================

Name: common_prog_delay_line_w_valid

Overview:
- Runtime-programmable, multi-channel delay line with valid qualification.
- N_CH data lanes share one valid. The delay is selectable at run time from 0 to MAX_DELAY without re-synthesis.
- Reconfiguration and flush discard in-flight samples safely, count the discarded samples, and flag a settling window.
- Used wherever pipeline-alignment delays must be trimmed by register or firmware, for example latency matching between parallel datapaths.

Parameters:
- NB_DATA, 8, bits per channel.
- N_CH, 4, number of channels sharing one valid.
- MAX_DELAY, 16, largest selectable delay (≥1).
- NB_DELAY, 5, width of i_delay; must satisfy 2^NB_DELAY > MAX_DELAY.
- RESET_DELAY, 4, delay applied after reset (≤ MAX_DELAY).
- NB_CNT, 16, width of the drop counter.

Ports:
- i_clock, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_data_in, in, N_CH*NB_DATA, channel c occupies bits [c*NB_DATA +: NB_DATA].
- i_valid, in, 1, input sample valid.
- i_delay, in, NB_DELAY, requested delay in valid-cycles; values above MAX_DELAY saturate to MAX_DELAY.
- i_flush, in, 1, single-cycle pulse that discards all in-flight samples.
- i_clr_drop, in, 1, clears the drop counter.
- o_data_out, out, N_CH*NB_DATA, delayed data.
- o_valid, out, 1, delayed valid.
- o_delay, out, NB_DELAY, currently applied delay (delay_q).
- o_busy, out, 1, high while in SETTLE.
- o_drop_count, out, NB_CNT, saturating count of discarded valid samples.

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset is synchronous and active-high.
- Reset values:
  - All valid stages = 0; data stages = 0.
  - delay_q = RESET_DELAY; state = RUN; settle counter = 0.
  - o_drop_count = 0; o_busy = 0; o_valid = 0.
- Chain: MAX_DELAY stages, each N_CH*NB_DATA data bits plus 1 valid bit.
  - The valid shift register shifts every cycle.
  - Data stage 0 loads i_data_in only when i_valid is high.
  - Data stage k loads stage k-1 only when valid[k-1] is high. Data holds otherwise, to save power.
- Output tap:
  - delay_q=0: o_data_out=i_data_in and o_valid=i_valid, combinational bypass.
  - delay_q=D≥1: o_data_out=data[D-1] and o_valid = valid[D-1] AND (state==RUN).
  - A sample with i_valid=1 at edge n appears with o_valid=1 in cycle n+D.
- Reconfiguration (d_sat = saturated i_delay; evaluated every cycle, in both states): if d_sat != delay_q, then at that edge:
  - delay_q <= d_sat.
  - All valid bits <= 0, including stage 0; the i_valid of that cycle is discarded.
  - Settle counter <= d_sat; state <= SETTLE if d_sat>0, else RUN.
- Flush: i_flush=1 with no delay change. Same as reconfiguration with d_sat = delay_q: clear the chain and settle for delay_q cycles.
- Delay change and i_flush in the same cycle: treated as a single reconfiguration event; drops are counted once.
- SETTLE:
  - o_busy=1 and o_valid is forced to 0.
  - Counter decrements each cycle; when it is 1, the next state is RUN.
  - Inputs accepted during SETTLE propagate normally.
  - A new change or flush during SETTLE restarts the event with the new value.
- Drop counter: on each clear event, add popcount(valid[0..delay_q_old-1]) + i_valid. Addition saturates at 2^NB_CNT-1.
  - The delay_q=0 bypass discards only i_valid.
  - i_clr_drop sets the count to 0. If it coincides with a clear event, the result equals that event's drop count.
- Reset mid-SETTLE or mid-stream overrides everything and returns to the reset values above.

Test Plan:
- Reset, D=4, i_valid=1 continuously with data 0x01,0x02,… → o_valid rises at cycle 4; o_data_out sequence = input delayed by exactly 4 cycles; o_drop_count=0.
- Gapped valid (1,0,0,1,1), D=3 → o_valid pattern is the same gaps shifted by 3 cycles; data matches per valid sample; data holds during gaps.
- Streaming at D=4 with 4 samples in flight, change i_delay to 7 → o_busy high for 7 cycles, o_valid=0 throughout, o_drop_count=5 (4 in flight + 1 input); first new sample out 7 cycles after input.
- i_delay=31 with MAX_DELAY=16 → o_delay=16 and 16-cycle latency. i_delay=0 → bypass, same-cycle output, o_busy stays 0.
- i_flush at D=5 with 3 in flight, i_valid=0, simultaneous i_clr_drop → count=3; o_busy 5 cycles. A second flush during SETTLE restarts the 5-cycle window.
- Preload o_drop_count near 0xFFFF via repeated flushes (NB_CNT=4 for the test) → count saturates at 15. i_reset asserted mid-SETTLE → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/common_prog_delay_line_w_valid.sv
// Multi-channel delay line with a run-time selectable delay and a shared valid.
// Delay changes and flushes clear in-flight samples, count them, and hold o_valid low while the chain refills.
module common_prog_delay_line_w_valid #(
    parameter int NB_DATA     = 8,
    parameter int N_CH        = 4,
    parameter int MAX_DELAY   = 16,
    parameter int NB_DELAY    = 5,
    parameter int RESET_DELAY = 4,
    parameter int NB_CNT      = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [N_CH*NB_DATA-1:0]   i_data_in,
    input  logic                      i_valid,
    input  logic [NB_DELAY-1:0]       i_delay,
    input  logic                      i_flush,
    input  logic                      i_clr_drop,
    output logic [N_CH*NB_DATA-1:0]   o_data_out,
    output logic                      o_valid,
    output logic [NB_DELAY-1:0]       o_delay,
    output logic                      o_busy,
    output logic [NB_CNT-1:0]         o_drop_count
);

    localparam int W      = N_CH * NB_DATA;
    localparam int NB_POP = $clog2(MAX_DELAY + 2);
    localparam int NB_SUM = ((NB_CNT > NB_POP) ? NB_CNT : NB_POP) + 1;

    typedef enum logic {RUN, SETTLE} state_t;

    state_t                state_q, state_d;
    logic [NB_DELAY-1:0]   delay_q, delay_d;
    logic [NB_DELAY-1:0]   cnt_q, cnt_d;
    logic [NB_DELAY-1:0]   d_sat;
    logic [NB_CNT-1:0]     drop_q, drop_d;
    logic [NB_CNT-1:0]     drop_base;
    logic [NB_SUM-1:0]     drops;
    logic                  clear_event;
    logic [MAX_DELAY-1:0]  vld_q;
    logic [W-1:0]          data_q [MAX_DELAY];

    function automatic logic [NB_DELAY-1:0] sat_delay(input logic [NB_DELAY-1:0] d);
        return (d > NB_DELAY'(MAX_DELAY)) ? NB_DELAY'(MAX_DELAY) : d;
    endfunction

    // Only the stages in front of the active tap hold samples that would have been delivered.
    function automatic logic [NB_SUM-1:0] pop_below(input logic [MAX_DELAY-1:0] v,
                                                    input logic [NB_DELAY-1:0] d);
        logic [NB_SUM-1:0] n;
        n = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (k < int'(d) && v[k]) n = n + NB_SUM'(1);
        end
        return n;
    endfunction

    function automatic logic [NB_CNT-1:0] sat_add(input logic [NB_CNT-1:0] a,
                                                  input logic [NB_SUM-1:0] b);
        logic [NB_SUM-1:0] s;
        s = NB_SUM'(a) + b;
        return (s > NB_SUM'({NB_CNT{1'b1}})) ? {NB_CNT{1'b1}} : s[NB_CNT-1:0];
    endfunction

    always_comb begin
        d_sat       = sat_delay(i_delay);
        clear_event = (d_sat != delay_q) || i_flush;
        drops       = pop_below(vld_q, delay_q) + NB_SUM'(i_valid);
        drop_base   = i_clr_drop ? '0 : drop_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        delay_d     = delay_q;
        drop_d      = drop_base;
        if (clear_event) begin
            delay_d = d_sat;
            cnt_d   = d_sat;
            state_d = (d_sat != '0) ? SETTLE : RUN;
            drop_d  = sat_add(drop_base, drops);
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q - NB_DELAY'(1);
            if (cnt_q == NB_DELAY'(1)) state_d = RUN;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= RUN;
            delay_q <= NB_DELAY'(RESET_DELAY);
            cnt_q   <= '0;
            drop_q  <= '0;
            vld_q   <= '0;
            for (int k = 0; k < MAX_DELAY; k++) data_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            vld_q[0] <= clear_event ? 1'b0 : i_valid;
            for (int k = 1; k < MAX_DELAY; k++) begin
                vld_q[k] <= clear_event ? 1'b0 : vld_q[k-1];
            end
            // Data registers only move when a valid sample is shifting into them.
            if (i_valid) data_q[0] <= i_data_in;
            for (int k = 1; k < MAX_DELAY; k++) begin
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    always_comb begin
        o_data_out = i_data_in;
        o_valid    = i_valid;
        if (delay_q != '0) begin
            o_data_out = '0;
            o_valid    = 1'b0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (delay_q == NB_DELAY'(k + 1)) begin
                    o_data_out = data_q[k];
                    o_valid    = vld_q[k] && (state_q == RUN);
                end
            end
        end
    end

    assign o_delay      = delay_q;
    assign o_busy       = (state_q == SETTLE);
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_common_prog_delay_line_w_valid.sv
// Directed bench for common_prog_delay_line_w_valid (4-bit drop counter so saturation is reachable).
module tb_common_prog_delay_line_w_valid;

    localparam int NB_DATA = 8, N_CH = 4, MAX_DELAY = 16, NB_DELAY = 5, RESET_DELAY = 4, NB_CNT = 4;
    localparam int W = N_CH * NB_DATA;

    logic                clk = 1'b0;
    logic                rst, valid, flush, clr_drop;
    logic [W-1:0]        data_in;
    logic [NB_DELAY-1:0] delay;
    logic [W-1:0]        data_out;
    logic                out_valid, busy;
    logic [NB_DELAY-1:0] out_delay;
    logic [NB_CNT-1:0]   drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    common_prog_delay_line_w_valid #(
        .NB_DATA(NB_DATA), .N_CH(N_CH), .MAX_DELAY(MAX_DELAY),
        .NB_DELAY(NB_DELAY), .RESET_DELAY(RESET_DELAY), .NB_CNT(NB_CNT)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_data_in(data_in), .i_valid(valid),
        .i_delay(delay), .i_flush(flush), .i_clr_drop(clr_drop),
        .o_data_out(data_out), .o_valid(out_valid), .o_delay(out_delay),
        .o_busy(busy), .o_drop_count(drop_count)
    );

    function automatic logic [W-1:0] mkdata(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b ^ 8'hC0, b ^ 8'h80, b ^ 8'h40, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; flush = 1'b0; clr_drop = 1'b0; delay = 5'd4; data_in = '0;
        tick(); tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (out_delay !== 5'd4) begin n_fail++; $display("FAIL reset_delay got %0d exp 4", out_delay); end
        n_checks++; if (drop_count !== 4'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream_d4();
        logic exp_v;
        for (int i = 0; i < 17; i++) begin
            valid = (i < 12); data_in = mkdata(i + 1);
            @(negedge clk);
            exp_v = (i >= 4) && (i < 16);
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid i=%0d got %b exp %b", i, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data_out !== mkdata(i - 3)) begin n_fail++; $display("FAIL stream_data i=%0d got %h exp %h", i, data_out, mkdata(i - 3)); end
            end
            tick();
        end
        valid = 1'b0;
        @(negedge clk);
        n_checks++; if (drop_count !== 4'd0) begin n_fail++; $display("FAIL stream_drop got %0d exp 0", drop_count); end
        tick();
    endtask

    task automatic test_gapped_d3();
        int   pat [10] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        int   last;
        logic exp_v;
        delay = 5'd3; valid = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_settle_busy j=%0d got %b exp 1", j, busy); end
            tick();
        end
        last = -1;
        for (int i = 0; i < 10; i++) begin
            valid = (pat[i] != 0); data_in = mkdata(100 + i);
            @(negedge clk);
            exp_v = (i >= 3) && (pat[(i >= 3) ? i - 3 : 0] != 0);
            if (exp_v) last = i - 3;
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL gap_valid i=%0d got %b exp %b", i, out_valid, exp_v); end
            if (last >= 0) begin
                n_checks++; if (data_out !== mkdata(100 + last)) begin n_fail++; $display("FAIL gap_data i=%0d got %h exp %h", i, data_out, mkdata(100 + last)); end
            end
            if (i == 0) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_busy_end got %b exp 0", busy); end
            end
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_reconfig_4_to_7();
        delay = 5'd4; valid = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) tick();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; data_in = mkdata(200 + i);
            tick();
        end
        delay = 5'd7; valid = 1'b1; data_in = mkdata(204);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || data_out !== mkdata(200)) begin n_fail++; $display("FAIL reconf_pre v=%b d=%h exp 1 %h", out_valid, data_out, mkdata(200)); end
        tick();
        for (int j = 0; j < 8; j++) begin
            valid = (j == 0); data_in = mkdata(300 + j);
            @(negedge clk);
            n_checks++; if (busy !== (j < 7)) begin n_fail++; $display("FAIL reconf_busy j=%0d got %b exp %b", j, busy, (j < 7)); end
            n_checks++; if (out_valid !== (j == 7)) begin n_fail++; $display("FAIL reconf_valid j=%0d got %b exp %b", j, out_valid, (j == 7)); end
            if (j == 7) begin
                n_checks++; if (data_out !== mkdata(300)) begin n_fail++; $display("FAIL reconf_data got %h exp %h", data_out, mkdata(300)); end
            end
            if (j == 0) begin
                n_checks++; if (drop_count !== 4'd5) begin n_fail++; $display("FAIL reconf_drop got %0d exp 5", drop_count); end
                n_checks++; if (out_delay !== 5'd7) begin n_fail++; $display("FAIL reconf_delay got %0d exp 7", out_delay); end
            end
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_delay_saturate();
        delay = 5'd31; valid = 1'b0;
        tick();
        for (int j = 0; j < 17; j++) begin
            valid = (j == 0); data_in = mkdata(400);
            @(negedge clk);
            n_checks++; if (busy !== (j < 16)) begin n_fail++; $display("FAIL sat_busy j=%0d got %b exp %b", j, busy, (j < 16)); end
            n_checks++; if (out_valid !== (j == 16)) begin n_fail++; $display("FAIL sat_valid j=%0d got %b exp %b", j, out_valid, (j == 16)); end
            if (j == 0) begin
                n_checks++; if (out_delay !== 5'd16) begin n_fail++; $display("FAIL sat_delay got %0d exp 16", out_delay); end
            end
            if (j == 16) begin
                n_checks++; if (data_out !== mkdata(400)) begin n_fail++; $display("FAIL sat_data got %h exp %h", data_out, mkdata(400)); end
            end
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_bypass();
        int vb [4] = '{1, 0, 1, 1};
        delay = 5'd0; valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            valid = (vb[k] != 0); data_in = mkdata(500 + k);
            @(negedge clk);
            n_checks++; if (out_valid !== (vb[k] != 0)) begin n_fail++; $display("FAIL byp_valid k=%0d got %b exp %b", k, out_valid, (vb[k] != 0)); end
            n_checks++; if (data_out !== mkdata(500 + k)) begin n_fail++; $display("FAIL byp_data k=%0d got %h exp %h", k, data_out, mkdata(500 + k)); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL byp_busy k=%0d got %b exp 0", k, busy); end
            if (k == 0) begin
                n_checks++; if (out_delay !== 5'd0) begin n_fail++; $display("FAIL byp_delay got %0d exp 0", out_delay); end
            end
            tick();
        end
        flush = 1'b1; valid = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_checks++; if (drop_count !== 4'd6) begin n_fail++; $display("FAIL byp_drop got %0d exp 6", drop_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL byp_flush_busy got %b exp 0", busy); end
        tick();
    endtask

    task automatic test_flush_d5();
        delay = 5'd5; valid = 1'b0;
        tick();
        for (int j = 0; j < 5; j++) tick();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; data_in = mkdata(600 + i);
            tick();
        end
        valid = 1'b0; flush = 1'b1; clr_drop = 1'b1;
        tick();
        flush = 1'b0; clr_drop = 1'b0;
        for (int j = 0; j < 9; j++) begin
            flush = (j == 2);
            @(negedge clk);
            n_checks++; if (busy !== (j < 8)) begin n_fail++; $display("FAIL flush_busy j=%0d got %b exp %b", j, busy, (j < 8)); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid j=%0d got %b exp 0", j, out_valid); end
            if (j == 0 || j == 8) begin
                n_checks++; if (drop_count !== 4'd3) begin n_fail++; $display("FAIL flush_drop j=%0d got %0d exp 3", j, drop_count); end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_drop_saturation();
        for (int k = 0; k < 10; k++) begin
            flush = 1'b1; valid = 1'b1;
            @(negedge clk);
            n_checks++; if (drop_count !== 4'(3 + k)) begin n_fail++; $display("FAIL dsat_step k=%0d got %0d exp %0d", k, drop_count, 3 + k); end
            tick();
        end
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; data_in = mkdata(700 + i);
            tick();
        end
        flush = 1'b1; valid = 1'b1;
        @(negedge clk);
        n_checks++; if (drop_count !== 4'd13) begin n_fail++; $display("FAIL dsat_pre got %0d exp 13", drop_count); end
        tick();
        flush = 1'b1; valid = 1'b1;
        @(negedge clk);
        n_checks++; if (drop_count !== 4'd15) begin n_fail++; $display("FAIL dsat_jump got %0d exp 15", drop_count); end
        tick();
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_checks++; if (drop_count !== 4'd15) begin n_fail++; $display("FAIL dsat_hold got %0d exp 15", drop_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dsat_busy got %b exp 1", busy); end
        tick();
    endtask

    task automatic test_reset_mid_settle();
        rst = 1'b1; delay = 5'd4;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst2_busy got %b exp 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_valid got %b exp 0", out_valid); end
        n_checks++; if (out_delay !== 5'd4) begin n_fail++; $display("FAIL rst2_delay got %0d exp 4", out_delay); end
        n_checks++; if (drop_count !== 4'd0) begin n_fail++; $display("FAIL rst2_drop got %0d exp 0", drop_count); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL rst2_data got %h exp 0", data_out); end
        tick();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; clr_drop = 1'b0; delay = 5'd4; data_in = '0;
        #1;
        test_reset();
        test_stream_d4();
        test_gapped_d3();
        test_reconfig_4_to_7();
        test_delay_saturate();
        test_bypass();
        test_flush_d5();
        test_drop_saturation();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
